// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: pipeline-side view of the hazard controller (hazard inputs in, stall/flush controls and counters out).
interface pipe_hazard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_d;
    logic [4:0]       rs2_d;
    logic [4:0]       rd_e;
    logic             mem_read_e;
    logic             pc_src_e;
    logic             imem_ready;
    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic             flush_e;
    logic             imem_req;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    modport master (
        output rs1_d, rs2_d, rd_e, mem_read_e, pc_src_e, imem_ready,
        input  stall_f, stall_d, flush_d, flush_e, imem_req, stall_cnt, flush_cnt
    );
    modport slave (
        input  rs1_d, rs2_d, rd_e, mem_read_e, pc_src_e, imem_ready,
        output stall_f, stall_d, flush_d, flush_e, imem_req, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage core, covering load-use, redirects and a
// variable-latency instruction fetch, with saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int RESET_HOLD = 2,
    parameter int CNT_W      = 32
) (
    input logic          clk,
    input logic          rst_i,
    pipe_hazard_if.slave hz
);
    typedef enum logic [1:0] {INIT, RUN, IWAIT, DISCARD} state_t;
    state_t           state, state_nx, state_eff;
    logic [3:0]       hold;
    logic             lu, stall_f, stall_d, flush_d, flush_e, imem_req;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    assign lu = hz.mem_read_e && hz.rd_e != 5'd0 && (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
    // Reset forces the INIT response immediately, so the pipeline is held even before the first edge.
    assign state_eff = rst_i ? INIT : state;
    always_comb begin
        state_nx = state_eff;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        imem_req = 1'b0;
        case (state_eff)
            INIT: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
                flush_e = 1'b1;
                if (hold == '0) state_nx = RUN;
            end
            DISCARD: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
                if (hz.imem_ready) state_nx = RUN;
            end
            default: begin
                imem_req = 1'b1;
                if (hz.pc_src_e) begin
                    flush_d  = 1'b1;
                    flush_e  = 1'b1;
                    state_nx = hz.imem_ready ? RUN : DISCARD;
                end else if (lu) begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    flush_e  = 1'b1;
                    state_nx = hz.imem_ready ? RUN : IWAIT;
                end else if (!hz.imem_ready) begin
                    stall_f  = 1'b1;
                    flush_d  = 1'b1;
                    state_nx = IWAIT;
                end else begin
                    state_nx = RUN;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state     <= INIT;
            hold      <= 4'(RESET_HOLD - 1);
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT && hold != '0) hold <= hold - 4'd1;
            if (stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if ((flush_d || flush_e) && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
    assign hz.stall_f   = stall_f;
    assign hz.stall_d   = stall_d;
    assign hz.flush_d   = flush_d;
    assign hz.flush_e   = flush_e;
    assign hz.imem_req  = imem_req;
    assign hz.stall_cnt = stall_cnt;
    assign hz.flush_cnt = flush_cnt;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core.
- Drives stallF, stallD, flushD and flushE into the PC/pipeline registers. Sources: load-use hazards, taken branches/jumps (pcSrcE) and a variable-latency instruction memory with a request/ready handshake.
- Tracks fetches still in flight across a redirect so stale instructions never reach ID.
- Keeps cycle counters of stall and flush events for performance debug.

Parameters:
- RESET_HOLD, 2, cycles after reset release during which fetch stays stalled; range 1..15.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- rs1_d  in  5  source register 1 of the instruction in ID.
- rs2_d  in  5  source register 2 of the instruction in ID.
- rd_e  in  5  destination register of the instruction in EX.
- mem_read_e  in  1  the EX instruction is a load.
- pc_src_e  in  1  taken branch/jump resolved in EX (PC pcSrcE).
- imem_ready  in  1  instruction memory returns the word for the current request this cycle.
- stall_f  out  1  hold the PC register (stallF).
- stall_d  out  1  hold the IF/ID register (stallD).
- flush_d  out  1  zero the IF/ID register (flushD).
- flush_e  out  1  zero the ID/EX register (flushE).
- imem_req  out  1  fetch request valid for the current PC.
- stall_cnt  out  CNT_W  cycles with stall_f=1 since reset.
- flush_cnt  out  CNT_W  cycles with flush_d=1 or flush_e=1 since reset.

Behaviour:
- States: INIT, RUN, IWAIT, DISCARD. Next-state logic and counters are registered. All pipeline-control outputs are combinational from state and inputs: same-cycle response.
- Reset (rst_i=1 at an edge): state=INIT, hold counter=RESET_HOLD-1, stall_cnt=0, flush_cnt=0.
  - Reset outputs: stall_f=1, stall_d=0, flush_d=1, flush_e=1, imem_req=0.
  - Reset mid-operation abandons any outstanding fetch with no further response.
- INIT:
  - Outputs: stall_f=1, flush_d=1, flush_e=1, imem_req=0.
  - Counter decrements each cycle. Go to RUN in the cycle after the counter reaches 0, i.e. exactly RESET_HOLD cycles in INIT.
- Load-use hazard: lu = mem_read_e & (rd_e!=0) & (rd_e==rs1_d | rd_e==rs2_d). Register x0 never creates a hazard.
- RUN/IWAIT output priority, highest first:
  1. pc_src_e=1:
     - Outputs: flush_d=1, flush_e=1, stall_f=0, stall_d=0. The PC loads the branch target.
     - If imem_ready=0 that cycle, go to DISCARD. Otherwise go to RUN.
  2. lu=1:
     - Outputs: stall_f=1, stall_d=1, flush_e=1, flush_d=0. Exactly one bubble per hazard.
     - The bubble clears rd_e, so lu drops the next cycle with no extra state.
     - A load-use stall overrides fetch completion: if imem_ready=1 in this cycle, that word is accepted and the PC is still held.
  3. imem_ready=0:
     - Outputs: stall_f=1, flush_d=1 (bubble into ID; the ID instruction advances normally), stall_d=0, flush_e=0.
     - Go to IWAIT.
  4. Otherwise: all controls 0. Go to RUN.
- imem_req=1 in RUN and IWAIT, 0 in INIT and DISCARD.
- DISCARD (stale fetch in flight after a redirect):
  - Outputs: imem_req=0, stall_f=1, flush_d=1, flush_e=0.
  - On imem_ready=1 the stale word is dropped and the state goes to RUN.
  - pc_src_e cannot be 1 here, because EX holds bubbles; if it is, it is ignored.
- Counters:
  - stall_cnt increments on every cycle with stall_f=1, INIT included.
  - flush_cnt increments on every cycle with flush_d|flush_e.
  - Both saturate at all-ones, with no wrap-around.

Test Plan:
- Reset: hold rst_i=1 for 3 cycles, then release with imem_ready=1 → stall_f=1 for exactly 2 cycles after release, then imem_req=1 and all controls 0; stall_cnt=2 and flush_cnt=2 (INIT cycles only; reset-asserted cycles are not counted).
- Load-use: mem_read_e=1, rd_e=5, rs2_d=5, held one cycle then rd_e=0 → one cycle of stall_f=stall_d=flush_e=1; with rd_e=0 and rs1_d=0 there is no stall.
- Taken branch: pc_src_e=1 with imem_ready=1 → flush_d=flush_e=1 and stall_f=0 in that cycle; state remains RUN; flush_cnt increases by 1.
- Imem wait: imem_ready low for 3 cycles → stall_f=flush_d=1 for those 3 cycles, stall_d=0; controls clear on the cycle imem_ready=1; stall_cnt increases by 3.
- Redirect during wait: in IWAIT, pc_src_e=1 with imem_ready=0, then imem_ready=1 two cycles later → DISCARD with imem_req=0; the stale word is dropped with flush_d=1; state returns to RUN and imem_req=1 the next cycle.
- Priority and saturation: lu=1 and pc_src_e=1 together → flush-only response (stall_d=0). Force stall_cnt to all-ones and stall once more → value holds at all-ones.
